// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU bus between two requesters, the arbiter and the ALU.
// slave is the arbiter side, master is the requester/ALU environment side.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_in0;
    logic [DATA_W-1:0] req0_in1;
    logic [2:0]        req0_op;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_data;
    logic              resp0_ready;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_in0;
    logic [DATA_W-1:0] req1_in1;
    logic [2:0]        req1_op;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_data;
    logic              resp1_ready;

    logic [DATA_W-1:0] alu_in0;
    logic [DATA_W-1:0] alu_in1;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              busy;

    modport slave (
        input  req0_valid, req0_in0, req0_in1, req0_op, resp0_ready,
        input  req1_valid, req1_in0, req1_in1, req1_op, resp1_ready,
        input  alu_out,
        output req0_ready, resp0_valid, resp0_data,
        output req1_ready, resp1_valid, resp1_data,
        output alu_in0, alu_in1, alu_op, busy
    );

    modport master (
        output req0_valid, req0_in0, req0_in1, req0_op, resp0_ready,
        output req1_valid, req1_in0, req1_in1, req1_op, resp1_ready,
        output alu_out,
        input  req0_ready, resp0_valid, resp0_data,
        input  req1_ready, resp1_valid, resp1_data,
        input  alu_in0, alu_in1, alu_op, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input logic         clk,
    input logic         reset_n,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] in0_q, in1_q, res_q;
    logic [2:0]        op_q;
    logic              gnt_q;
    logic              gnt_sel, accept, consume;

`ifdef ALU_ARB_RR_EN
    // rr_q names the requester preferred on the next simultaneous request.
    logic rr_q;

    assign gnt_sel = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else if (accept) begin
            rr_q <= ~gnt_sel;
        end
    end
`else
    assign gnt_sel = ~bus.req0_valid;
`endif

    assign accept  = reset_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign consume = (state_q == RESP) && (gnt_q ? bus.resp1_ready : bus.resp0_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (consume) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            in0_q   <= '0;
            in1_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q <= gnt_sel;
                in0_q <= gnt_sel ? bus.req1_in0 : bus.req0_in0;
                in1_q <= gnt_sel ? bus.req1_in1 : bus.req0_in1;
                op_q  <= gnt_sel ? bus.req1_op  : bus.req0_op;
            end
            if (state_q == EXEC) begin
                res_q <= bus.alu_out;
            end
        end
    end

    // Every output is gated by reset_n so the bus reads 0 while reset is held.
    always_comb begin
        bus.req0_ready  = accept && !gnt_sel;
        bus.req1_ready  = accept && gnt_sel;
        bus.resp0_valid = reset_n && (state_q == RESP) && !gnt_q;
        bus.resp1_valid = reset_n && (state_q == RESP) && gnt_q;
        bus.resp0_data  = bus.resp0_valid ? res_q : '0;
        bus.resp1_data  = bus.resp1_valid ? res_q : '0;
        bus.alu_in0     = (reset_n && (state_q == EXEC)) ? in0_q : '0;
        bus.alu_in1     = (reset_n && (state_q == EXEC)) ? in1_q : '0;
        bus.alu_op      = (reset_n && (state_q == EXEC)) ? op_q  : '0;
        bus.busy        = reset_n && (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SL16 = 3'd5;
    localparam logic [2:0] OP_SR1  = 3'd6;
    localparam logic [2:0] OP_UND  = 3'd7;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32)) bus ();
    alu_arbiter #(.DATA_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SL16: return b << 16;
            OP_SR1:  return a >> 1;
            default: return 32'h0;
        endcase
    endfunction

    always_comb bus.alu_out = alu_f(bus.alu_op, bus.alu_in0, bus.alu_in1);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending op, its age in cycles since accept, last granted id.
    bit          m_pend = 1'b0;
    bit          m_id   = 1'b0;
    int          m_age  = 0;
    bit          m_last = 1'b1;
    logic [31:0] m_res  = '0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [2:0]  m_op   = '0;
    int          gnt_hist[$];

    logic [1:0]  obs_rdy, obs_rv;
    logic [31:0] obs_rd0, obs_rd1;
    logic        obs_busy;

    task automatic drive_req(input bit n, input bit v, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (n) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_in0 = a; bus.req1_in1 = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_in0 = a; bus.req0_in1 = b;
        end
    endtask

    task automatic set_rr(input bit n, input bit v);
        if (n) bus.resp1_ready = v;
        else   bus.resp0_ready = v;
    endtask

    // One clock: compare all outputs at negedge, advance the model at posedge.
    task automatic cycle();
        bit v0, v1, g, acc, rv0, rv1, ex;
        bit rr0, rr1;
        logic [31:0] ga, gb;
        logic [2:0]  gop;
        @(negedge clk);
        obs_rdy  = {bus.req1_ready, bus.req0_ready};
        obs_rv   = {bus.resp1_valid, bus.resp0_valid};
        obs_rd0  = bus.resp0_data;
        obs_rd1  = bus.resp1_data;
        obs_busy = bus.busy;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        rr0 = bus.resp0_ready;
        rr1 = bus.resp1_ready;
        g   = (v0 && v1) ? (RR ? !m_last : 1'b0) : v1;
        acc = reset_n && !m_pend && (v0 || v1);
        rv0 = reset_n && m_pend && (m_age >= 2) && !m_id;
        rv1 = reset_n && m_pend && (m_age >= 2) && m_id;
        ex  = reset_n && m_pend && (m_age == 1);
        check("req0_ready", bus.req0_ready, acc && !g);
        check("req1_ready", bus.req1_ready, acc && g);
        check("resp0_valid", bus.resp0_valid, rv0);
        check("resp1_valid", bus.resp1_valid, rv1);
        check("resp0_data", bus.resp0_data, rv0 ? m_res : 32'h0);
        check("resp1_data", bus.resp1_data, rv1 ? m_res : 32'h0);
        check("alu_in0", bus.alu_in0, ex ? m_a : 32'h0);
        check("alu_in1", bus.alu_in1, ex ? m_b : 32'h0);
        check("alu_op", {29'h0, bus.alu_op}, {29'h0, ex ? m_op : 3'h0});
        check("busy", bus.busy, reset_n && m_pend);
        ga  = g ? bus.req1_in0 : bus.req0_in0;
        gb  = g ? bus.req1_in1 : bus.req0_in1;
        gop = g ? bus.req1_op  : bus.req0_op;
        @(posedge clk);
        if (!reset_n) begin
            m_pend = 1'b0;
            m_last = 1'b1;
        end else begin
            if (m_pend && (m_age >= 2) && (m_id ? rr1 : rr0)) m_pend = 1'b0;
            else if (m_pend) m_age++;
            if (acc) begin
                m_pend = 1'b1; m_age = 1; m_id = g; m_last = g;
                m_a = ga; m_b = gb; m_op = gop; m_res = alu_f(gop, ga, gb);
                gnt_hist.push_back(int'(g));
            end
        end
        #1;
    endtask

    task automatic drain();
        drive_req(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (4) cycle();
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          other;
        int          hold;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int n;
        bit o;
        o = !v.id;
        drive_req(v.id, 1'b1, v.op, v.a, v.b);
        drive_req(o, v.other, OP_ADD, 32'h1, 32'h1);
        set_rr(v.id, 1'b0);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_rdy[v.id] && n < 10);
        check({v.name, "_accept"}, obs_rdy[v.id], 1'b1);
        drive_req(v.id, 1'b0, v.op, v.a, v.b);
        cycle();
        check({v.name, "_exec_busy"}, obs_busy, 1'b1);
        check({v.name, "_exec_noresp"}, obs_rv[v.id], 1'b0);
        set_rr(v.id, v.hold == 0);
        cycle();
        check({v.name, "_lat2_valid"}, obs_rv[v.id], 1'b1);
        check({v.name, "_data"}, v.id ? obs_rd1 : obs_rd0, v.exp);
        check({v.name, "_other_valid"}, obs_rv[o], 1'b0);
        check({v.name, "_other_data"}, o ? obs_rd1 : obs_rd0, 32'h0);
        for (int i = 1; i < v.hold; i++) begin
            cycle();
            check({v.name, "_hold_valid"}, obs_rv[v.id], 1'b1);
            check({v.name, "_hold_data"}, v.id ? obs_rd1 : obs_rd0, v.exp);
            check({v.name, "_hold_other_rdy"}, obs_rdy[o], 1'b0);
        end
        if (v.hold > 0) begin
            set_rr(v.id, 1'b1);
            cycle();
            check({v.name, "_consume_valid"}, obs_rv[v.id], 1'b1);
            check({v.name, "_consume_other_rdy"}, obs_rdy[o], 1'b0);
        end
        set_rr(v.id, 1'b0);
        cycle();
        check({v.name, "_idle_busy"}, obs_busy, 1'b0);
        if (v.other) check({v.name, "_next_accept"}, obs_rdy[o], 1'b1);
        drain();
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        bit gr;
        vecs[0] = '{"add0",  1'b0, OP_ADD,  32'h00123456, 32'h00654321, 32'h00777777, 1'b0, 0};
        vecs[1] = '{"sub1",  1'b1, OP_SUB,  32'h00123456, 32'h00654321, 32'hFFACF135, 1'b0, 0};
        vecs[2] = '{"or1",   1'b1, OP_OR,   32'h00123456, 32'h00654321, 32'h00777777, 1'b0, 0};
        vecs[3] = '{"sl16",  1'b1, OP_SL16, 32'h00123456, 32'h00654321, 32'h43210000, 1'b0, 0};
        vecs[4] = '{"und07", 1'b0, OP_UND,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 5};

        reset_n = 1'b0;
        drive_req(1'b0, 1'b1, OP_ADD, 32'h1, 32'h2);
        drive_req(1'b1, 1'b1, OP_ADD, 32'h3, 32'h4);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        #1;
        repeat (2) cycle();
        check("reset_ready", {30'h0, obs_rdy}, 32'h0);
        check("reset_busy", obs_busy, 1'b0);
        drive_req(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
        reset_n = 1'b1;
        cycle();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters valid back to back with immediate consume.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        gnt_hist.delete();
        drive_req(1'b0, 1'b1, OP_ADD, 32'h10, 32'h20);
        drive_req(1'b1, 1'b1, OP_ADD, 32'h30, 32'h40);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        n = 0;
        while (gnt_hist.size() < 4 && n < 30) begin
            cycle();
            n++;
        end
        check("both_grant_count", gnt_hist.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < gnt_hist.size(); i++) begin
            gr = RR ? (i % 2 == 1) : 1'b0;
            check("both_grant_order", gnt_hist[i], gr);
        end
        drain();

        // Reset while the operation is in EXEC discards it.
        drive_req(1'b0, 1'b1, OP_ADD, 32'h11, 32'h22);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_rdy[0] && n < 10);
        check("rst_exec_accept", obs_rdy[0], 1'b1);
        drive_req(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        reset_n = 1'b0;
        cycle();
        check("rst_exec_busy", obs_busy, 1'b0);
        reset_n = 1'b1;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (3) begin
            cycle();
            check("rst_exec_noresp", {30'h0, obs_rv}, 32'h0);
            check("rst_exec_idle", obs_busy, 1'b0);
        end
        drive_req(1'b1, 1'b1, OP_SUB, 32'h9, 32'h3);
        drive_req(1'b0, 1'b1, OP_ADD, 32'h9, 32'h3);
        cycle();
        check("rst_exec_prefer0", {30'h0, obs_rdy}, 32'h1);
        drain();

        // Random traffic including withdrawals, stalls, undefined ops and resets.
        for (int c = 0; c < 2000; c++) begin
            for (int r = 0; r < 2; r++) begin
                bit cur;
                cur = r ? bus.req1_valid : bus.req0_valid;
                if (!cur || obs_rdy[r]) begin
                    drive_req(r[0], 1'(($urandom_range(0, 2)) != 0), 3'($urandom_range(0, 7)),
                              $urandom, $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    drive_req(r[0], 1'b0, OP_ADD, 32'h0, 32'h0);
                end
            end
            bus.resp0_ready = 1'($urandom_range(0, 1));
            bus.resp1_ready = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset_n = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL equal the ALU datapath width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_in0, reqN_in1  input  DATA_W  operands from requester N.
REQ-007 reqN_op  input  3  ALU opcode from requester N, using the codebase ALU_OP_* encodings.
REQ-008 respN_valid  output  1  result for requester N is held on respN_data.
REQ-009 respN_data  output  DATA_W  result for requester N.
REQ-010 respN_ready  input  1  requester N consumes its result.
REQ-011 alu_in0, alu_in1  output  DATA_W  operands to the shared ALU.
REQ-012 alu_op  output  3  opcode to the shared ALU.
REQ-013 alu_out  input  DATA_W  combinational result from the shared ALU.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
- REQ-015 The arbiter SHALL own one FSM with states IDLE, EXEC and RESP; it holds at most one operation in flight.
- REQ-016 IDLE: if any reqN_valid is high, the arbiter SHALL assert reqN_ready combinationally for exactly one granted N.
  - On that edge it SHALL latch in0/in1/op and the grant ID, then move to EXEC.
  - With no valid requests it SHALL stay in IDLE.
- REQ-017 EXEC: alu_in0/alu_in1/alu_op SHALL drive the latched values.
  - alu_out SHALL be captured into the result register at the end of the cycle.
  - The FSM SHALL then move to RESP.
- REQ-018 Outside EXEC, alu_in0, alu_in1 and alu_op SHALL be driven to 0.
- REQ-019 RESP: respN_valid SHALL be high for the granted N only, and respN_data SHALL hold the result register value.
  - The FSM SHALL stay in RESP until respN_ready is high, then return to IDLE on that edge.
- REQ-020 Latency: an operation accepted at edge T SHALL have its response valid from cycle T+2; the minimum issue interval is 3 cycles.
- REQ-021 reqN_ready SHALL be low in EXEC and RESP, and a new request SHALL NOT be accepted in the cycle a response is consumed.
- REQ-022 respM_data for the non-granted requester SHALL read 0; respM_ready for the non-granted requester SHALL be ignored.
- REQ-023 Opcodes SHALL be passed through unmodified, including undefined ones; the result is whatever alu_out returns.
- REQ-024 A requester deasserting valid without a ready handshake SHALL NOT be granted, and no state SHALL change.

Reset
- REQ-025 While reset_n is low at a clock edge:
  - state SHALL go to IDLE;
  - operand, opcode, result and grant registers SHALL clear to 0;
  - the round-robin pointer SHALL clear to 0, meaning requester 0 is preferred next.
- REQ-026 During reset, all outputs SHALL be 0: reqN_ready, respN_valid, respN_data, alu_*, busy.
- REQ-027 Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight operation with no response delivered.

Configuration
- REQ-028 Macro ALU_ARB_RR_EN defined: round-robin arbitration.
  - When both requests are valid in IDLE, grant goes to the requester not granted most recently.
  - The pointer updates only on an accept.
- REQ-029 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins a simultaneous request; no pointer register SHALL exist.

Verification
- REQ-030 req0 in0=0x00123456 in1=0x00654321 op=ADD, resp0_ready=1 -> resp0_valid at T+2 with 0x00777777, then busy=0 at T+3.
- REQ-031 req1 SUB with same operands -> resp1_data=0xFFACF135 and resp0_valid stays 0; then OR -> 0x00777777; then SL16 -> 0x43210000.
- REQ-032 Both valid continuously, each op ADD, responses consumed immediately:
  - with ALU_ARB_RR_EN, grants alternate 0,1,0,1;
  - without the macro, grants are 0,0,0,0.
- REQ-033 resp0_ready held low 5 cycles in RESP -> resp0_valid and data stable for those 5 cycles, req1_ready stays 0, then accept proceeds after the consume edge.
- REQ-034 reset_n pulsed low during EXEC -> no response; all outputs read 0 after the edge; the next request from req1 (with req0 also valid) is granted to req0.
- REQ-035 Undefined op=3'b111 with in0=in1=5 -> response 0, and the FSM completes normally.
